// File: rtl/read_stream_stage.sv
// rtl/read_stream_stage.sv - FIFO read-side pop engine with a 2-entry buffer presenting a valid/ready stream
// Tracks the one-cycle RAM read latency with an inflight flag so the buffer never overflows.
module read_stream_stage #(
  parameter int DATA_SIZE    = 8,
  parameter int ADDRESS_SIZE = 4
) (
  input  logic                   rclk,
  input  logic                   rreset,
  input  logic                   rempty,
  output logic                   rinc,
  input  logic [DATA_SIZE-1:0]   rdata,
  input  logic                   flush,
  output logic                   m_valid,
  output logic [DATA_SIZE-1:0]   m_data,
  input  logic                   m_ready,
  output logic [ADDRESS_SIZE:0]  pop_count
);

  logic [1:0]            r_count;
  logic                  r_inflight;
  logic                  r_valid;
  logic [DATA_SIZE-1:0]  r_head;
  logic [DATA_SIZE-1:0]  r_tail;
  logic [ADDRESS_SIZE:0] r_pop_count;

  logic                  w_pop;
  logic [1:0]            w_level;
  logic [1:0]            w_after_pop;
  logic [1:0]            w_count_next;
  logic                  w_inflight_next;
  logic [DATA_SIZE-1:0]  w_head_next;
  logic [DATA_SIZE-1:0]  w_tail_next;
  logic [ADDRESS_SIZE:0] w_pop_count_next;

  // count + inflight never exceeds 2, so the post-pop level fits in two bits.
  always_comb begin
    w_pop       = r_valid & m_ready;
    w_level     = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    w_after_pop = r_count - {1'b0, w_pop};
    rinc        = ~rempty & ~flush & ~rreset & (w_level < 2'd2);
  end

  always_comb begin
    w_head_next      = r_head;
    w_tail_next      = r_tail;
    w_count_next     = flush ? 2'd0 : w_level;
    w_inflight_next  = rinc;
    w_pop_count_next = r_pop_count + {{ADDRESS_SIZE{1'b0}}, w_pop};
    if (w_pop && (r_count == 2'd2)) begin
      w_head_next = r_tail;
    end
    // The arriving word lands behind whatever survives this cycle's pop.
    if (r_inflight && !flush) begin
      if (w_after_pop == 2'd0) begin
        w_head_next = rdata;
      end else begin
        w_tail_next = rdata;
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (rreset) begin
      r_count     <= 2'd0;
      r_inflight  <= 1'b0;
      r_valid     <= 1'b0;
      r_head      <= '0;
      r_tail      <= '0;
      r_pop_count <= '0;
    end else begin
      r_count     <= w_count_next;
      r_inflight  <= w_inflight_next;
      r_valid     <= (w_count_next != 2'd0);
      r_head      <= w_head_next;
      r_tail      <= w_tail_next;
      r_pop_count <= w_pop_count_next;
    end
  end

  assign m_valid   = r_valid;
  assign m_data    = r_head;
  assign pop_count = r_pop_count;

endmodule

// File: tb/tb_read_stream_stage.sv
// tb/tb_read_stream_stage.sv - directed bench with a queue-level reference model for read_stream_stage
module tb_read_stream_stage;

  logic       rclk;
  logic       rreset;
  logic       rempty;
  logic       rinc;
  logic [7:0] rdata;
  logic       flush;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [4:0] pop_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  logic [7:0] src_q[$];
  logic [7:0] fill = 8'hC0;

  read_stream_stage dut (
    .rclk      (rclk),
    .rreset    (rreset),
    .rempty    (rempty),
    .rinc      (rinc),
    .rdata     (rdata),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .pop_count (pop_count)
  );

  initial rclk = 0;
  always #5 rclk = ~rclk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  // FIFO memory model: a pop request returns the next word one cycle later.
  initial begin
    bit fired;
    forever begin
      @(negedge rclk);
      fired = (rinc === 1'b1);
      @(posedge rclk);
      #1;
      if (fired) begin
        if (src_q.size() != 0) rdata = src_q.pop_front();
        else begin
          rdata = fill;
          fill  = fill + 8'd1;
        end
      end else begin
        rdata = 8'hEE;
      end
    end
  end

  // Reference model: an ordered queue of buffered words plus the word requested last cycle.
  logic [7:0] mq[$];
  bit         m_infl = 0;
  int         exp_pc = 0;

  always @(negedge rclk) begin
    if (cmp_en) begin
      bit exp_valid;
      bit pop;
      bit exp_rinc;
      exp_valid = (mq.size() != 0);
      chk("m_valid", m_valid, exp_valid);
      if (exp_valid) chk("m_data", m_data, mq[0]);
      pop      = exp_valid && (m_ready === 1'b1);
      exp_rinc = !rempty && !flush && !rreset && ((mq.size() + int'(m_infl) - int'(pop)) < 2);
      chk("rinc", rinc, exp_rinc);
      chk("pop_count", pop_count, exp_pc % 32);
      if (rreset) begin
        mq.delete();
        m_infl = 0;
        exp_pc = 0;
      end else begin
        if (pop) begin
          void'(mq.pop_front());
          exp_pc++;
        end
        if (flush) begin
          mq.delete();
          m_infl = 0;
        end else begin
          if (m_infl) mq.push_back(rdata);
          m_infl = exp_rinc;
        end
      end
    end
  end

  initial begin
    int pulses;
    int seen_valid;
    rreset = 1; rempty = 1; flush = 0; m_ready = 0; rdata = 8'hEE;
    tick(); tick();
    #1;
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_pop_count", pop_count, 0);
    chk("reset_rinc", rinc, 0);
    cmp_en = 1;

    // Basic streaming: three words, one per cycle.
    src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
    tick(); rreset = 0; rempty = 0; m_ready = 1; #1;
    chk("c1_rinc", rinc, 1);
    tick(); #1;
    chk("c2_m_valid", m_valid, 0);
    tick(); #1;
    chk("c3_m_valid", m_valid, 1);
    chk("c3_m_data", m_data, 8'h11);
    tick(); rempty = 1; #1;
    chk("c4_m_data", m_data, 8'h22);
    tick(); #1;
    chk("c5_m_data", m_data, 8'h33);
    tick(); #1;
    chk("c6_m_valid", m_valid, 0);
    chk("c6_pop_count", pop_count, 3);

    // Backpressure: buffer fills to two and holds.
    src_q.push_back(8'h31); src_q.push_back(8'h32); src_q.push_back(8'h33); src_q.push_back(8'h34);
    tick(); rempty = 0; m_ready = 0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (rinc === 1'b1) pulses++;
      tick();
    end
    #1;
    chk("bp_pulses", pulses, 2);
    chk("bp_hold_valid", m_valid, 1);
    chk("bp_hold_data", m_data, 8'h31);
    m_ready = 1; #1;
    chk("bp_rinc_resume", rinc, 1);
    tick(); #1;
    chk("bp_second_word", m_data, 8'h32);
    tick(); rempty = 1;
    repeat (5) tick();

    // Empty FIFO: no pops until rempty drops for one cycle.
    pulses = 0; seen_valid = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (rinc === 1'b1) pulses++;
      if (m_valid === 1'b1) seen_valid++;
      tick();
    end
    chk("empty_pulses", pulses, 0);
    chk("empty_valid", seen_valid, 0);
    src_q.push_back(8'h5A);
    tick(); rempty = 0; #1;
    chk("single_rinc", rinc, 1);
    tick(); rempty = 1; #1;
    chk("single_n1_valid", m_valid, 0);
    tick(); #1;
    chk("single_n2_valid", m_valid, 1);
    chk("single_n2_data", m_data, 8'h5A);
    tick(); #1;
    chk("single_done", m_valid, 0);

    // Flush with full buffer, then flush during streaming with a word in flight.
    src_q.push_back(8'hA1); src_q.push_back(8'hA2);
    tick(); m_ready = 0; rempty = 0;
    repeat (3) tick();
    #1;
    chk("full_valid", m_valid, 1);
    chk("full_data", m_data, 8'hA1);
    chk("full_pop_count", pop_count, 8);
    for (int i = 0; i < 6; i++) src_q.push_back(8'hB1 + 8'(i));
    flush = 1; #1;
    chk("flush_rinc", rinc, 0);
    tick(); flush = 0; #1;
    chk("post_flush_valid", m_valid, 0);
    chk("post_flush_pop_count", pop_count, 8);
    chk("post_flush_rinc", rinc, 1);
    m_ready = 1;
    repeat (4) tick();
    tick(); flush = 1; #1;
    chk("flush2_valid", m_valid, 1);
    chk("flush2_data", m_data, 8'hB4);
    tick(); flush = 0; #1;
    chk("flush2_after_valid", m_valid, 0);
    chk("flush2_pop_count", pop_count, 12);
    tick(); rempty = 1;
    tick(); #1;
    chk("fresh_valid", m_valid, 1);
    chk("fresh_data", m_data, 8'hB6);

    // pop_count wrap: 33 words after a fresh reset.
    tick(); rreset = 1; m_ready = 1; rempty = 1;
    tick(); rreset = 0; rempty = 0; #1;
    chk("wrap_start_pop_count", pop_count, 0);
    for (int i = 0; i < 33; i++) src_q.push_back(8'h40 + 8'(i));
    repeat (33) tick();
    rempty = 1;
    repeat (4) tick();
    #1;
    chk("wrap_pop_count", pop_count, 1);
    chk("wrap_drained", m_valid, 0);

    // Reset with a full buffer and a pop pending.
    src_q.push_back(8'hC1); src_q.push_back(8'hC2);
    tick(); m_ready = 0; rempty = 0;
    repeat (3) tick();
    #1;
    chk("rstA_full_data", m_data, 8'hC1);
    rreset = 1; m_ready = 1; #1;
    chk("rstA_rinc", rinc, 0);
    tick(); rreset = 0; m_ready = 0; rempty = 1; #1;
    chk("rstA_valid", m_valid, 0);
    chk("rstA_data", m_data, 0);
    chk("rstA_pop_count", pop_count, 0);

    // Reset while streaming with a word in flight.
    src_q.push_back(8'hD1); src_q.push_back(8'hD2); src_q.push_back(8'hD3);
    tick(); rempty = 0; m_ready = 1;
    repeat (3) tick();
    rreset = 1; #1;
    chk("rstB_rinc", rinc, 0);
    tick(); rreset = 0; rempty = 1; #1;
    chk("rstB_valid", m_valid, 0);
    chk("rstB_data", m_data, 0);
    chk("rstB_pop_count", pop_count, 0);
    repeat (3) tick();
    #1;
    chk("rstB_inflight_dropped", m_valid, 0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/read_stream_stage.md
READ_STREAM_STAGE -- requirements
Module: read_stream_stage

Interface
REQ-001 Parameter DATA_SIZE, default 8, width of FIFO memory read data and stream payload.
REQ-002 Parameter ADDRESS_SIZE, default 4, FIFO address width, used only for the popped-word counter width.
REQ-003 rclk  input  1  read-domain clock; all logic on rising edge.
REQ-004 rreset  input  1  synchronous, active-high reset sampled on rclk.
REQ-005 rempty  input  1  FIFO empty flag from read-side empty logic; no pop issued while high.
REQ-006 rinc  output  1  pop request to read-side pointer logic; combinational.
REQ-007 rdata  input  DATA_SIZE  FIFO memory read data, valid exactly one cycle after the cycle rinc was high.
REQ-008 flush  input  1  synchronous discard of all buffered and in-flight words.
REQ-009 m_valid  output  1  stream output word valid; registered.
REQ-010 m_data  output  DATA_SIZE  stream output payload; registered, head of buffer.
REQ-011 m_ready  input  1  downstream accept; transfer when m_valid & m_ready.
REQ-012 pop_count  output  ADDRESS_SIZE+1  free-running count of words delivered on stream, wraps mod 2^(ADDRESS_SIZE+1).

Function
REQ-013 Internal storage: 2-entry data buffer (head, tail), count register 0..2, inflight flag (registered copy of rinc).
REQ-014 pop = m_valid & m_ready; m_valid SHALL equal (count != 0); m_data SHALL equal head entry.
REQ-015 rinc SHALL be high iff !rempty & !flush & !rreset & (count + inflight - pop) < 2.
REQ-016 inflight SHALL register rinc each cycle (cleared by reset or flush).
REQ-017 When inflight is high, rdata SHALL be written into buffer at end of that cycle: into head if count - pop == 0, else into tail.
REQ-018 On pop with count == 2, tail SHALL move to head in same cycle; simultaneous pop and capture SHALL keep order (oldest word first).
REQ-019 count next = count + inflight - pop; count SHALL never exceed 2 or underflow.
REQ-020 Latency: rinc high in cycle N, buffer empty -> m_valid high in cycle N+2 with that word.
REQ-021 Throughput: with rempty low and m_ready held high, one word per cycle in steady state.
REQ-022 m_ready low with count == 2 -> rinc SHALL stay low; m_valid and m_data SHALL hold stable until accepted.
REQ-023 m_valid SHALL NOT drop without pop except on flush or reset.
REQ-024 flush high: rinc low that cycle; next cycle count = 0, inflight = 0, m_valid = 0; rdata arriving in the flush cycle SHALL be discarded; pop_count unaffected, and a pop in the flush cycle SHALL still count.
REQ-025 pop_count SHALL increment by 1 on each pop; wraps from all-ones to 0.
REQ-026 rempty rising while a pop is in flight SHALL not cancel the in-flight word; it is captured normally.

Reset
REQ-027 rreset high at a rising edge: count = 0, inflight = 0, m_valid = 0, m_data = 0, pop_count = 0, buffer entries = 0.
REQ-028 rinc SHALL be low during any cycle rreset is high; rdata arriving during reset SHALL be discarded.
REQ-029 Reset asserted mid-transfer SHALL take effect at the next edge regardless of m_ready or inflight.

Verification
REQ-030 Reset, rempty=0, m_ready=1, rdata sequence 0x11,0x22,0x33 -> rinc high from cycle 1, m_data 0x11,0x22,0x33 on consecutive cycles from cycle 3, pop_count = 3.
REQ-031 m_ready=0, rempty=0 -> exactly two rinc pulses, count = 2, m_data holds first word; then m_ready=1 for 2 cycles -> both words delivered in order, rinc resumes.
REQ-032 rempty=1 throughout -> rinc never high, m_valid stays 0; deassert rempty one cycle -> one word, m_valid 2 cycles later.
REQ-033 Buffer full (0xA1,0xA2) plus flush with m_ready=0 -> next cycle m_valid = 0, count = 0, pop_count unchanged; following traffic starts fresh.
REQ-034 2^(ADDRESS_SIZE+1)+1 pops with defaults (33) -> pop_count wraps to 1.
REQ-035 rreset asserted with count = 2 and inflight = 1 -> next cycle all outputs 0, rinc low during reset cycle.
